uart_rx: RTL and testbench



---
 rtl/uart_rx_if.sv | 21 ++
 rtl/uart_rx.sv | 148 ++++++++++++++
 tb/tb_uart_rx.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-byte bundle from uart_rx to downstream capture/control logic
interface uart_rx_if;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    modport master (
        output data,
        output data_valid,
        output frame_err,
        output busy
    );

    modport slave (
        input data,
        input data_valid,
        input frame_err,
        input busy
    );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampled 8N1 UART receiver; define UART_RX_MAJORITY_EN for 3-sample majority voting
module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic      clk_rx,
    input  logic      rst,
    input  logic      rxd,
    uart_rx_if.master rx_if
);
    localparam int HALF = OVERSAMPLE / 2;
    localparam int CW   = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] OS_M1   = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    data_q, data_d;
    logic          dv_q, dv_d;
    logic          fe_q, fe_d;
    logic          rxd_m, rxd_s;
    logic          sample;

    // Both synchronizer flops reset to the idle level so reset never fakes a start bit.
    always_ff @(posedge clk_rx) begin
        if (rst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q;

    always_ff @(posedge clk_rx) begin
        if (rst) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], rxd_s};
        end
    end

    assign sample = (rxd_s & hist_q[0]) | (rxd_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    assign sample = rxd_s;
`endif

    always_ff @(posedge clk_rx) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shreg_q   <= 8'h00;
            data_q    <= 8'h00;
            dv_q      <= 1'b0;
            fe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            dv_q      <= dv_d;
            fe_q      <= fe_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        dv_d      = 1'b0;
        fe_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rxd_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    state_d   = sample ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == OS_M1) begin
                    shreg_d[bit_idx_q] = sample;
                    cnt_d              = '0;
                    bit_idx_d          = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == OS_M1) begin
                    cnt_d = '0;
                    if (sample) begin
                        data_d  = shreg_q;
                        dv_d    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // A held-low line (break) must return high before another start bit is trusted.
            WAIT_IDLE: begin
                if (rxd_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rx_if.data       = data_q;
    assign rx_if.data_valid = dv_q;
    assign rx_if.frame_err  = fe_q;
    assign rx_if.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx against a frame-level reference model
module tb_uart_rx;
    localparam int OS   = 16;
    localparam int HALF = OS / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam bit MAJ = 1'b1;
`else
    localparam bit MAJ = 1'b0;
`endif

    logic clk_rx;
    logic rst;
    logic rxd;

    uart_rx_if u_if ();

    uart_rx #(.OVERSAMPLE(OS)) dut (
        .clk_rx(clk_rx),
        .rst   (rst),
        .rxd   (rxd),
        .rx_if (u_if)
    );

    int passed;
    int total;
    int cyc;
    int start_cyc;
    int fe_cnt;
    int both_cnt;
    logic [7:0] dv_q[$];
    int         dv_cyc_q[$];
    logic       dv_busy_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] snap_data;
    logic       snap_dv, snap_fe, snap_busy;

    initial begin
        clk_rx = 1'b0;
        forever #5 clk_rx = ~clk_rx;
    end

    // Observer: collects every strobe with its cycle stamp, sampled 1ns after the edge.
    always begin
        @(posedge clk_rx);
        cyc++;
        #1;
        if (u_if.data_valid === 1'b1) begin
            dv_q.push_back(u_if.data);
            dv_cyc_q.push_back(cyc);
            dv_busy_q.push_back(u_if.busy);
        end
        if (u_if.frame_err === 1'b1) fe_cnt++;
        if (u_if.data_valid === 1'b1 && u_if.frame_err === 1'b1) both_cnt++;
    end

    task automatic clear_obs();
        dv_q.delete();
        dv_cyc_q.delete();
        dv_busy_q.delete();
        exp_q.delete();
        fe_cnt = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_rx);
            rxd = 1'b1;
        end
    endtask

    // Drives one 10-bit frame, each bit held OS cycles; optional glitch at every data-bit
    // midpoint and optional one-cycle reset in the middle of data bit 4.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input bit glitch, input bit rst_mid);
        for (int i = 0; i < 10; i++) begin
            logic v;
            if (i == 0) v = 1'b0;
            else if (i == 9) v = stop_bit;
            else v = b[i-1];
            for (int c = 0; c < OS; c++) begin
                @(negedge clk_rx);
                if (i == 0 && c == 0) start_cyc = cyc + 1;
                rxd = v ^ (glitch && i >= 1 && i <= 8 && c == HALF);
                if (rst_mid && i == 5 && c == HALF) rst = 1'b1;
                if (rst_mid && i == 5 && c == HALF + 1) begin
                    rst       = 1'b0;
                    snap_data = u_if.data;
                    snap_dv   = u_if.data_valid;
                    snap_fe   = u_if.frame_err;
                    snap_busy = u_if.busy;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rxd = 1'b1;
        repeat (3) @(negedge clk_rx);
        rst = 1'b0;
        @(negedge clk_rx);
        total++; if (u_if.data !== 8'h00) $display("FAIL reset_data: got %h want 00", u_if.data); else passed++;
        total++; if (u_if.data_valid !== 1'b0) $display("FAIL reset_dv: got %b want 0", u_if.data_valid); else passed++;
        total++; if (u_if.frame_err !== 1'b0) $display("FAIL reset_fe: got %b want 0", u_if.frame_err); else passed++;
        total++; if (u_if.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", u_if.busy); else passed++;
    endtask

    task automatic test_single();
        clear_obs();
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        idle(OS);
        total++; if (dv_q.size() != 1) $display("FAIL single_count: got %0d want 1", dv_q.size()); else passed++;
        if (dv_q.size() >= 1) begin
            total++; if (dv_q[0] !== 8'hA5) $display("FAIL single_data: got %h want a5", dv_q[0]); else passed++;
            total++; if (dv_cyc_q[0] - start_cyc != 154) $display("FAIL single_latency: got %0d want 154", dv_cyc_q[0] - start_cyc); else passed++;
            total++; if (dv_busy_q[0] !== 1'b0) $display("FAIL single_busy_at_strobe: got %b want 0", dv_busy_q[0]); else passed++;
        end
        total++; if (fe_cnt != 0) $display("FAIL single_fe: got %0d want 0", fe_cnt); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h3C;
        clear_obs();
        for (int i = 0; i < 3; i++) send_frame(bytes[i], 1'b1, 1'b0, 1'b0);
        idle(OS);
        total++; if (dv_q.size() != 3) $display("FAIL b2b_count: got %0d want 3", dv_q.size()); else passed++;
        for (int i = 0; i < 3 && i < dv_q.size(); i++) begin
            total++; if (dv_q[i] !== bytes[i]) $display("FAIL b2b_data%0d: got %h want %h", i, dv_q[i], bytes[i]); else passed++;
            if (i > 0) begin
                total++;
                if (dv_cyc_q[i] - dv_cyc_q[i-1] != 10 * OS)
                    $display("FAIL b2b_spacing%0d: got %0d want %0d", i, dv_cyc_q[i] - dv_cyc_q[i-1], 10 * OS);
                else passed++;
            end
        end
    endtask

    task automatic test_glitch_start();
        clear_obs();
        repeat (4) begin
            @(negedge clk_rx);
            rxd = 1'b0;
        end
        idle(3 * OS);
        total++; if (u_if.busy !== 1'b0) $display("FAIL glitch_busy: got %b want 0", u_if.busy); else passed++;
        total++; if (dv_q.size() != 0 || fe_cnt != 0) $display("FAIL glitch_strobe: got dv=%0d fe=%0d want 0/0", dv_q.size(), fe_cnt); else passed++;
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        idle(OS);
        total++; if (dv_q.size() != 1 || dv_q[0] !== 8'h5A) $display("FAIL glitch_next_frame: got n=%0d d=%h want 1/5a", dv_q.size(), u_if.data); else passed++;
    endtask

    task automatic test_frame_err();
        clear_obs();
        send_frame(8'h81, 1'b0, 1'b0, 1'b0);
        repeat (40 * OS) begin
            @(negedge clk_rx);
            rxd = 1'b0;
        end
        total++; if (u_if.busy !== 1'b1) $display("FAIL ferr_busy_hold: got %b want 1", u_if.busy); else passed++;
        total++; if (fe_cnt != 1) $display("FAIL ferr_count: got %0d want 1", fe_cnt); else passed++;
        total++; if (dv_q.size() != 0) $display("FAIL ferr_no_dv: got %0d want 0", dv_q.size()); else passed++;
        total++; if (u_if.data !== 8'h5A) $display("FAIL ferr_data_kept: got %h want 5a", u_if.data); else passed++;
        idle(2 * OS);
        total++; if (u_if.busy !== 1'b0) $display("FAIL ferr_busy_release: got %b want 0", u_if.busy); else passed++;
        send_frame(8'h42, 1'b1, 1'b0, 1'b0);
        idle(OS);
        total++; if (dv_q.size() != 1 || fe_cnt != 1 || u_if.data !== 8'h42) $display("FAIL ferr_recover: got n=%0d fe=%0d d=%h want 1/1/42", dv_q.size(), fe_cnt, u_if.data); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        b = {4'hF, 4'($urandom_range(15))};
        clear_obs();
        send_frame(b, 1'b1, 1'b0, 1'b1);
        idle(OS);
        total++;
        if (snap_data !== 8'h00 || snap_dv !== 1'b0 || snap_fe !== 1'b0 || snap_busy !== 1'b0)
            $display("FAIL rstmid_outputs: got d=%h dv=%b fe=%b busy=%b want 00/0/0/0", snap_data, snap_dv, snap_fe, snap_busy);
        else passed++;
        total++; if (dv_q.size() != 0 || fe_cnt != 0) $display("FAIL rstmid_no_strobe: got dv=%0d fe=%0d want 0/0", dv_q.size(), fe_cnt); else passed++;
        send_frame(8'h99, 1'b1, 1'b0, 1'b0);
        idle(OS);
        total++; if (dv_q.size() != 1 || u_if.data !== 8'h99) $display("FAIL rstmid_next_frame: got n=%0d d=%h want 1/99", dv_q.size(), u_if.data); else passed++;
    endtask

    task automatic test_sample_glitch();
        logic [7:0] bytes [2];
        logic [7:0] want;
        bytes[0] = 8'h6E;
        bytes[1] = 8'($urandom_range(255));
        for (int i = 0; i < 2; i++) begin
            clear_obs();
            want = MAJ ? bytes[i] : ~bytes[i];
            send_frame(bytes[i], 1'b1, 1'b1, 1'b0);
            idle(OS);
            total++;
            if (dv_q.size() != 1 || dv_q[0] !== want)
                $display("FAIL sample_glitch%0d: got n=%0d d=%h want 1/%h", i, dv_q.size(), u_if.data, want);
            else passed++;
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        clear_obs();
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom_range(255));
            exp_q.push_back(b);
            send_frame(b, 1'b1, 1'b0, 1'b0);
            idle($urandom_range(2) * OS);
        end
        idle(OS);
        total++; if (dv_q.size() != exp_q.size()) $display("FAIL rand_count: got %0d want %0d", dv_q.size(), exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size() && i < dv_q.size(); i++) begin
            total++; if (dv_q[i] !== exp_q[i]) $display("FAIL rand_data%0d: got %h want %h", i, dv_q[i], exp_q[i]); else passed++;
        end
        total++; if (fe_cnt != 0) $display("FAIL rand_fe: got %0d want 0", fe_cnt); else passed++;
    endtask

    initial begin
        passed   = 0;
        total    = 0;
        cyc      = 0;
        fe_cnt   = 0;
        both_cnt = 0;
        rst      = 1'b1;
        rxd      = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch_start();
        test_frame_err();
        test_reset_mid();
        test_sample_glitch();
        test_random();
        total++; if (both_cnt != 0) $display("FAIL dv_fe_overlap: got %0d want 0", both_cnt); else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
